seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial sequence detector, successor to the fixed-pattern detector.
- Pattern and length (1..MAX_LEN) are loaded at run time.
- Overlapping or non-overlapping detection is selectable per load.
- Inputs are qualified by a valid strobe; matches are counted in a saturating counter.
- Sits on a serial bit stream between the deserialiser front end and the control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
inp  in  1  serial data bit
in_valid  in  1  inp is sampled only when high
cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
out  out  1  one-cycle match pulse (registered)
match_count  out  CNT_W  saturating count of matches since last load/reset
cfg_err  out  1  last load had an illegal length
armed  out  1  high in the ARMED state

Behaviour:
- Reset (asynchronous): state=IDLE, pattern=0, len=0, overlap=0, history=0, fill=0, out=0, match_count=0, cfg_err=0, armed=0.
- History register: MAX_LEN-bit shift register. On each accepted bit (in_valid=1, no load), shift left with inp entering at bit 0.
- fill: count of accepted bits since the last load/match, saturating at len.
- Match condition: fill_next >= len and history_next[len-1:0] == pattern[len-1:0]. Compare masked to len bits.
- out is high for exactly one cycle, in the cycle after the edge that sampled the final pattern bit (latency 1). match_count increments on that same edge; it saturates at 2^CNT_W-1 with no wrap.
- States:
  - IDLE: no valid configuration; bits are ignored; out is never asserted.
  - HUNT: fill < len.
  - ARMED: fill == len; comparing every accepted bit.
- Transitions:
  - IDLE -> HUNT on a legal load.
  - HUNT -> ARMED when an accepted bit makes fill == len.
  - len==1 edge case: a legal load with len=1 goes to HUNT. The first accepted bit then evaluates the match and moves to ARMED in overlap mode; in non-overlap mode it stays in HUNT on a match.
  - ARMED, on a match with overlap=1: stay ARMED, fill stays len.
  - ARMED, on a match with overlap=0: fill=0, go to HUNT; history is not cleared, but stale bits are masked by fill.
  - Any state -> HUNT on a legal load, or -> IDLE on an illegal load.
- Legal load: 1 <= cfg_len <= MAX_LEN. It latches pattern/len/overlap and clears fill, history, match_count, out and cfg_err.
- Illegal load (cfg_len==0 or cfg_len > MAX_LEN): cfg_err=1, state=IDLE, match_count cleared, pattern/len are not updated.
- cfg_load and in_valid in the same cycle: the load wins and that bit is discarded.
- in_valid low: no shift, no fill change, out=0 next cycle.
- Reset mid-stream: everything returns to reset values immediately; the configuration is lost and a reload is required.

Decomposition:
- Package seq_det_pkg holds the state enum (IDLE, HUNT, ARMED) and the length-legality check function.
- One sub-module, seq_det_match_cnt: saturating counter with a clear input, CNT_W parameter.
- The shift/compare and the FSM stay in the top module.

Test Plan:
1. Reset then stimulus with no load: in_valid=1, inp alternating for 10 cycles -> out=0, match_count=0, armed=0, cfg_err=0 throughout.
2. Load pattern 4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> out pulses one cycle after the 4th and 7th bits; match_count=2.
3. Same stream with overlap=0 -> out pulses only after the 4th bit; match_count=1; state HUNT with fill=3 at the end.
4. Load with cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1, state IDLE, no out for any stream. A subsequent legal load clears cfg_err.
5. CNT_W=2, len=1, pattern=1, overlap=1, stream of six 1s -> six out pulses, match_count saturates at 3.
6. cfg_load with in_valid=1 in the same cycle, plus in_valid gaps mid-pattern 1,(gap),0,1,1 -> the colliding bit is dropped, the gap is ignored, and out pulses once after the final 1. Assert reset mid-pattern -> out=0 and armed=0 at once.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    ARMED = 2'd2
  } state_t;

  // A pattern length is usable only if it is between 1 and the history depth.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with synchronous clear; holds at all-ones.
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: loadable pattern/length,
// overlap select, valid-qualified input and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic               len_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;

  assign len_ok = len_legal(32'(cfg_len), MAX_LEN);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept    = in_valid && !cfg_load && (state != IDLE);
    hist_next = {history[MAX_LEN-2:0], inp};
    fill_inc  = (fill < len) ? fill + LEN_W'(1) : fill;
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    // Bits older than the pattern length are masked out of the compare.
    hit = accept && (fill_inc >= len) && (((hist_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      history <= '0;
      fill    <= '0;
      out     <= 1'b0;
      cfg_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      out <= 1'b0;
      if (cfg_load) begin
        history <= '0;
        fill    <= '0;
        armed   <= 1'b0;
        if (len_ok) begin
          state   <= HUNT;
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          cfg_err <= 1'b0;
        end else begin
          state   <= IDLE;
          cfg_err <= 1'b1;
        end
      end else if (accept) begin
        history <= hist_next;
        out     <= hit;
        if (hit && !overlap) begin
          // Non-overlapping: restart the fill; stale history stays masked by fill.
          fill  <= '0;
          state <= HUNT;
          armed <= 1'b0;
        end else if (fill_inc == len) begin
          fill  <= fill_inc;
          state <= ARMED;
          armed <= 1'b1;
        end else begin
          fill  <= fill_inc;
          state <= HUNT;
          armed <= 1'b0;
        end
      end
    end
  end

  seq_det_match_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cfg_load),
    .inc  (hit),
    .count(match_count)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog (default and 2-bit counter builds).
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               inp = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;

  logic               out, cfg_err, armed;
  logic [7:0]         match_count;
  logic               out2, cfg_err2, armed2;
  logic [1:0]         match_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out), .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
  );

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out2), .match_count(match_count2), .cfg_err(cfg_err2), .armed(armed2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic b);
    inp      = b;
    in_valid = 1'b1;
    tick();
  endtask

  // Bits are sent MSB first; expo holds the expected out after each bit.
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input logic [15:0] expo, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      check($sformatf("%s_out%0d", tag, n - 1 - i), out, expo[i]);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // 1. Reset state, then stimulus without any load.
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_cnt", match_count, 0);
    check("rst_armed", armed, 0);
    check("rst_err", cfg_err, 0);
    check("rst_out2", out2, 0);
    reset = 1'b0;
    run_stream("noload", 16'b1010101010, 16'b0, 10);
    check("noload_cnt", match_count, 0);
    check("noload_armed", armed, 0);
    check("noload_err", cfg_err, 0);

    // 2. Overlapping detection of 1011 in 1011011.
    load(8'b1011, 4'd4, 1'b1);
    check("ov_load_armed", armed, 0);
    run_stream("ov", 16'b1011011, 16'b0001001, 7);
    check("ov_cnt", match_count, 2);
    check("ov_armed", armed, 1);

    // 3. Non-overlapping: one match, then three bits of fill in HUNT.
    load(8'b1011, 4'd4, 1'b0);
    check("nov_load_cnt", match_count, 0);
    run_stream("nov", 16'b1011011, 16'b0001000, 7);
    check("nov_cnt", match_count, 1);
    check("nov_armed", armed, 0);
    check("nov_fill", u_dut.fill, 3);

    // 4. Illegal lengths 0 and 9 park the detector in IDLE.
    load(8'b1011, 4'd0, 1'b1);
    check("len0_err", cfg_err, 1);
    check("len0_cnt", match_count, 0);
    run_stream("len0", 16'b1011, 16'b0, 4);
    check("len0_armed", armed, 0);
    load(8'b1011, 4'd9, 1'b1);
    check("len9_err", cfg_err, 1);
    run_stream("len9", 16'b10111011, 16'b0, 8);
    check("len9_cnt", match_count, 0);
    load(8'b1011, 4'd4, 1'b1);
    check("legal_err_clr", cfg_err, 0);

    // 5. len=1 overlap: every 1 matches; 2-bit counter saturates at 3.
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(1'b1);
      check($sformatf("sat_out%0d", i), out2, 1);
      check($sformatf("sat_cnt2_%0d", i), match_count2, (i < 3) ? i + 1 : 3);
    end
    in_valid = 1'b0;
    tick();
    check("sat_out_idle", out2, 0);
    check("sat_cnt_full", match_count, 6);
    check("sat_cnt2_hold", match_count2, 3);

    // 6. Load collides with a valid bit; gap mid-pattern; async reset.
    inp      = 1'b1;
    in_valid = 1'b1;
    load(8'b1011, 4'd4, 1'b1);
    check("coll_fill", u_dut.fill, 0);
    check("coll_out", out, 0);
    send(1'b1);
    check("gap_b0", out, 0);
    in_valid = 1'b0;
    inp      = 1'b0;
    tick();
    check("gap_idle", out, 0);
    send(1'b0);
    check("gap_b1", out, 0);
    send(1'b1);
    check("gap_b2", out, 0);
    check("gap_b2_armed", armed, 0);
    send(1'b1);
    check("gap_hit", out, 1);
    check("gap_cnt", match_count, 1);
    check("gap_armed", armed, 1);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("arst_out", out, 0);
    check("arst_armed", armed, 0);
    check("arst_cnt", match_count, 0);
    tick();
    reset = 1'b0;
    run_stream("post_rst", 16'b1011, 16'b0, 4);
    check("post_rst_armed", armed, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
